title_scene_fx: RTL

- Next-generation start/title scene renderer for the 640x480 VGA path.
- Draws a parametrised, integer-scaled title image and an unscaled "press start" prompt sprite, with a colour-key for transparent prompt pixels.
- Runs a frame-synchronous fade-in → blink-wait → fade-out sequence and pulses `scene_done` so the top-level scene mux can advance.
- Sits between the VGA counter block and the two image BRAMs.

---
 rtl/scene_pkg.sv | 27 ++
 rtl/title_scene_fx_if.sv | 25 ++
 rtl/title_scene_fx_rgb_dimmer.sv | 25 ++
 rtl/title_scene_fx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
// Shared constants and pixel types for the VGA scene renderers.
package scene_pkg;

  localparam int unsigned H_ACTIVE      = 640;
  localparam int unsigned V_ACTIVE      = 480;
  localparam int unsigned CNT_W         = 10;
  localparam int unsigned PIX_W         = 12;
  localparam int unsigned TITLE_ADDR_W  = 17;
  localparam int unsigned PROMPT_ADDR_W = 11;
  localparam int unsigned BRIGHT_W      = 5;

  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 5'd16;

  typedef enum logic [1:0] {
    FADE_IN = 2'd0,
    WAIT    = 2'd1,
    EXIT    = 2'd2,
    DONE    = 2'd3
  } scene_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/title_scene_fx_if.sv
// Pixel-counter, BRAM and video-out bundle of the title scene.
interface title_scene_fx_if;
  import scene_pkg::*;

  logic [CNT_W-1:0]         h_cnt;
  logic [CNT_W-1:0]         v_cnt;
  logic                     start_req;
  logic [PIX_W-1:0]         mem_title_vga_data;
  logic [PIX_W-1:0]         mem_prompt_vga_data;
  logic [TITLE_ADDR_W-1:0]  title_pixel_addr;
  logic [PROMPT_ADDR_W-1:0] prompt_pixel_addr;
  logic [PIX_W-1:0]         vga_data;
  logic                     scene_done;

  modport master (
    output h_cnt, v_cnt, start_req, mem_title_vga_data, mem_prompt_vga_data,
    input  title_pixel_addr, prompt_pixel_addr, vga_data, scene_done
  );

  modport slave (
    input  h_cnt, v_cnt, start_req, mem_title_vga_data, mem_prompt_vga_data,
    output title_pixel_addr, prompt_pixel_addr, vga_data, scene_done
  );

endinterface

// File: rtl/title_scene_fx_rgb_dimmer.sv
// Combinational RGB444 brightness scaler; bright=16 is unity gain.
module rgb_dimmer
  import scene_pkg::*;
(
  input  rgb444_t             pix,
  input  logic [BRIGHT_W-1:0] bright,
  output rgb444_t             dimmed_c
);

  // 4b x 5b product, keep bits [7:4]; full scale passes the channel untouched
  function automatic logic [3:0] dim_channel(input logic [3:0] c, input logic [BRIGHT_W-1:0] b);
    logic [8:0] prod;
    prod = 9'(c) * 9'(b);
    return b[4] ? c : 4'(prod >> 4);
  endfunction

  // Scale each channel independently
  always_comb begin
    dimmed_c   = '0;
    dimmed_c.r = dim_channel(pix.r, bright);
    dimmed_c.g = dim_channel(pix.g, bright);
    dimmed_c.b = dim_channel(pix.b, bright);
  end

endmodule

// File: rtl/title_scene_fx.sv
// Title scene: scaled title image, colour-keyed prompt sprite, frame-synced fade/blink sequencing.
module title_scene_fx
  import scene_pkg::*;
#(
  parameter int unsigned IMG_W            = 240,
  parameter int unsigned IMG_H            = 240,
  parameter int unsigned SCALE_SHIFT      = 1,
  parameter int unsigned TITLE_H_START    = 80,
  parameter int unsigned TITLE_V_START    = 0,
  parameter int unsigned PROMPT_W         = 128,
  parameter int unsigned PROMPT_H         = 16,
  parameter int unsigned PROMPT_H_START   = 256,
  parameter int unsigned PROMPT_V_START   = 400,
  parameter logic [11:0] COLOR_KEY        = 12'h0F0,
  parameter int unsigned FADE_STEP_FRAMES = 2,
  parameter int unsigned BLINK_FRAMES     = 30,
  parameter int unsigned MEM_LATENCY      = 1
) (
  input logic             clk,
  input logic             rst,
  title_scene_fx_if.slave bus
);

  localparam int unsigned TITLE_W_SCR = IMG_W << SCALE_SHIFT;
  localparam int unsigned TITLE_H_SCR = IMG_H << SCALE_SHIFT;
  localparam int unsigned FRAME_W     = $clog2(FADE_STEP_FRAMES) + 1;
  localparam int unsigned BLINK_W     = $clog2(BLINK_FRAMES) + 1;
  localparam int unsigned FLAG_W      = 3;

  localparam logic [1:0] ST_FADE_IN = FADE_IN;
  localparam logic [1:0] ST_WAIT    = WAIT;
  localparam logic [1:0] ST_EXIT    = EXIT;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [31:0] h_ext, v_ext;
  logic [31:0] title_off_x, title_off_y, prompt_off_x, prompt_off_y;
  logic        active, in_title, in_prompt, frame_tick;

  // Offsets wrap to huge values left/above a region, so one unsigned compare bounds each side
  assign h_ext        = 32'(bus.h_cnt);
  assign v_ext        = 32'(bus.v_cnt);
  assign title_off_x  = h_ext - TITLE_H_START;
  assign title_off_y  = v_ext - TITLE_V_START;
  assign prompt_off_x = h_ext - PROMPT_H_START;
  assign prompt_off_y = v_ext - PROMPT_V_START;

  assign active    = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign in_title  = active && (title_off_x < TITLE_W_SCR) && (title_off_y < TITLE_H_SCR);
  assign in_prompt = active && (prompt_off_x < PROMPT_W) && (prompt_off_y < PROMPT_H);
  assign frame_tick = (bus.h_cnt == '0) && (bus.v_cnt == CNT_W'(V_ACTIVE));

  assign bus.title_pixel_addr = in_title ?
    TITLE_ADDR_W'((title_off_x >> SCALE_SHIFT) + IMG_W * (title_off_y >> SCALE_SHIFT)) : '0;
  assign bus.prompt_pixel_addr = in_prompt ?
    PROMPT_ADDR_W'(prompt_off_x + PROMPT_W * prompt_off_y) : '0;

  logic [FLAG_W-1:0] flag_pipe [MEM_LATENCY];
  logic              act_d, title_d, prompt_d;

  // Delay region flags by the BRAM latency so they line up with read data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) flag_pipe[i] <= '0;
    end else begin
      flag_pipe[0] <= {active, in_title, in_prompt};
      for (int i = 1; i < MEM_LATENCY; i++) flag_pipe[i] <= flag_pipe[i-1];
    end
  end

  assign {act_d, title_d, prompt_d} = flag_pipe[MEM_LATENCY-1];

  logic [1:0]          state, state_nxt;
  logic [BRIGHT_W-1:0] bright, bright_nxt;
  logic [FRAME_W-1:0]  frame_cnt, frame_nxt;
  logic [BLINK_W-1:0]  blink_cnt, blink_nxt;
  logic                prompt_vis, vis_nxt;
  logic                start_pend, pend_nxt;
  logic                done_reg, done_nxt;
  logic                frame_step;
  rgb444_t             sel_pix, dim_pix, vga_reg;

  // Prompt wins over title unless its pixel is the transparent key
  always_comb begin
    sel_pix = '0;
    if (act_d) begin
      if (prompt_d && prompt_vis && (bus.mem_prompt_vga_data != COLOR_KEY))
        sel_pix = rgb444_t'(bus.mem_prompt_vga_data);
      else if (title_d)
        sel_pix = rgb444_t'(bus.mem_title_vga_data);
    end
  end

  rgb_dimmer u_dimmer (
    .pix      (sel_pix),
    .bright   (bright),
    .dimmed_c (dim_pix)
  );

  assign frame_step = (frame_cnt == FRAME_W'(FADE_STEP_FRAMES - 1));

  // Scene sequencing; everything except start latching advances only on frame_tick
  always_comb begin
    state_nxt  = state;
    bright_nxt = bright;
    frame_nxt  = frame_cnt;
    blink_nxt  = blink_cnt;
    vis_nxt    = prompt_vis;
    pend_nxt   = start_pend;
    done_nxt   = 1'b0;
    if (bus.start_req && (state != ST_EXIT) && (state != ST_DONE)) pend_nxt = 1'b1;
    if (frame_tick) begin
      case (state)
        ST_FADE_IN: begin
          vis_nxt = 1'b0;
          if (frame_step) begin
            frame_nxt  = '0;
            bright_nxt = bright + 5'd1;
            if (bright == BRIGHT_MAX - 5'd1) begin
              state_nxt = ST_WAIT;
              vis_nxt   = 1'b1;
              blink_nxt = '0;
            end
          end else begin
            frame_nxt = frame_cnt + FRAME_W'(1);
          end
        end
        ST_WAIT: begin
          if (start_pend) begin
            state_nxt = ST_EXIT;
            pend_nxt  = 1'b0;
            vis_nxt   = 1'b1;
            frame_nxt = '0;
          end else if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_nxt = '0;
            vis_nxt   = ~prompt_vis;
          end else begin
            blink_nxt = blink_cnt + BLINK_W'(1);
          end
        end
        ST_EXIT: begin
          if (frame_step) begin
            frame_nxt  = '0;
            bright_nxt = bright - 5'd1;
            if (bright == 5'd1) begin
              state_nxt = ST_DONE;
              done_nxt  = 1'b1;
            end
          end else begin
            frame_nxt = frame_cnt + FRAME_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Scene state and registered pixel output
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FADE_IN;
      bright     <= '0;
      frame_cnt  <= '0;
      blink_cnt  <= '0;
      prompt_vis <= 1'b0;
      start_pend <= 1'b0;
      done_reg   <= 1'b0;
      vga_reg    <= '0;
    end else begin
      state      <= state_nxt;
      bright     <= bright_nxt;
      frame_cnt  <= frame_nxt;
      blink_cnt  <= blink_nxt;
      prompt_vis <= vis_nxt;
      start_pend <= pend_nxt;
      done_reg   <= done_nxt;
      vga_reg    <= dim_pix;
    end
  end

  assign bus.vga_data   = vga_reg;
  assign bus.scene_done = done_reg;

endmodule
